// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_unit                                                   |
// | Description : Instruction fetch stage. Reads one word from instruction     |
// |               memory at pc, offers it to decode, waits for the next-PC     |
// |               result, then fetches again.                                  |
// | Optional    : FETCH_ALIGN_CHECK_EN - trap misaligned next-PC targets       |
// |               into a sticky ERROR state (misalign=1). When undefined the   |
// |               low two bits of npc are cleared and misalign is tied to 0.   |
// | Ports       : clk, rst (async, active-low)                                 |
// |               imem_req/imem_addr/imem_ack/imem_rdata - memory read port    |
// |               pc/ir/ir_valid/ir_ready - instruction offered to decode      |
// |               npc_valid/npc - next-PC input                                |
// |               instr_cnt - instructions accepted by decode (wraps)          |
// |               misalign  - sticky misaligned-target flag                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        npc_valid,
  input  logic [31:0] npc,
  output logic [31:0] instr_cnt,
  output logic        misalign
);

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    HOLD     = 2'd1,
    WAIT_NPC = 2'd2,
    ERROR    = 2'd3
  } state_t;

  localparam logic [31:0] C_WORD_MASK = 32'hFFFF_FFFC;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_ir;
  logic [31:0] w_ir_nxt;
  logic [31:0] r_cnt;
  logic [31:0] w_cnt_nxt;
  logic        r_imem_req;
  logic        r_ir_valid;
  logic        w_npc_take;

`ifdef FETCH_ALIGN_CHECK_EN
  logic        r_misalign;
  logic        w_misalign_nxt;
`endif

  // Next-state / datapath decode
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_cnt_nxt   = r_cnt;
    w_npc_take  = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    w_misalign_nxt = r_misalign;
`endif

    case (r_state)
      FETCH: begin
        if (imem_ack) begin
          w_ir_nxt    = imem_rdata;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        // npc is only meaningful once decode has taken the instruction
        if (ir_ready) begin
          w_cnt_nxt = r_cnt + 32'd1;
          if (npc_valid) begin
            w_npc_take = 1'b1;
          end else begin
            w_state_nxt = WAIT_NPC;
          end
        end
      end
      WAIT_NPC: begin
        if (npc_valid) begin
          w_npc_take = 1'b1;
        end
      end
      ERROR: begin
        // Sticky until reset
      end
      default: begin
        w_state_nxt = FETCH;
      end
    endcase

    if (w_npc_take) begin
`ifdef FETCH_ALIGN_CHECK_EN
      if (npc[1:0] != 2'b00) begin
        w_misalign_nxt = 1'b1;
        w_state_nxt    = ERROR;
      end else begin
        w_pc_nxt    = npc;
        w_state_nxt = FETCH;
      end
`else
      w_pc_nxt    = npc & C_WORD_MASK;
      w_state_nxt = FETCH;
`endif
    end
  end

  // State and datapath registers. imem_req / ir_valid are flopped from the
  // next state so they are glitch-free decodes of the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_ir       <= 32'd0;
      r_cnt      <= 32'd0;
      r_imem_req <= 1'b1;
      r_ir_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_ir       <= w_ir_nxt;
      r_cnt      <= w_cnt_nxt;
      r_imem_req <= (w_state_nxt == FETCH);
      r_ir_valid <= (w_state_nxt == HOLD);
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_misalign_nxt;
    end
  end

  assign misalign = r_misalign;
`else
  assign misalign = 1'b0;
`endif

  assign imem_req  = r_imem_req;
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign ir        = r_ir;
  assign ir_valid  = r_ir_valid;
  assign instr_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fetch_unit                                                |
// | Description : Self-checking bench for fetch_unit. Directed scenarios plus  |
// |               a randomized run checked against a transaction-level model   |
// |               (expected pc / ir / instruction count per instruction).      |
// | Optional    : FETCH_ALIGN_CHECK_EN selects the misaligned-target checks.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] ir;
  logic        ir_valid;
  logic        ir_ready;
  logic        npc_valid;
  logic [31:0] npc;
  logic [31:0] instr_cnt;
  logic        misalign;

  int checks   = 0;
  int failures = 0;

  // Transaction-level model state
  logic [31:0] m_pc;
  logic [31:0] m_ir;
  logic [31:0] m_cnt;
  logic [31:0] nxt;

  fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .ir         (ir),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready),
    .npc_valid  (npc_valid),
    .npc        (npc),
    .instr_cnt  (instr_cnt),
    .misalign   (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected view of an instruction being offered to decode
  task automatic chk_hold(input string tag);
    chk({tag, ".ir_valid"}, {31'd0, ir_valid}, 32'd1);
    chk({tag, ".imem_req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, ".ir"},       ir,        m_ir);
    chk({tag, ".pc"},       pc,        m_pc);
    chk({tag, ".cnt"},      instr_cnt, m_cnt);
  endtask

  task automatic chk_fetch(input string tag);
    chk({tag, ".imem_req"}, {31'd0, imem_req}, 32'd1);
    chk({tag, ".ir_valid"}, {31'd0, ir_valid}, 32'd0);
    chk({tag, ".addr"},     imem_addr, m_pc);
    chk({tag, ".ir"},       ir,        m_ir);
    chk({tag, ".cnt"},      instr_cnt, m_cnt);
  endtask

  task automatic chk_wait(input string tag);
    chk({tag, ".imem_req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, ".ir_valid"}, {31'd0, ir_valid}, 32'd0);
    chk({tag, ".ir"},       ir,        m_ir);
    chk({tag, ".cnt"},      instr_cnt, m_cnt);
  endtask

  initial begin
    rst        = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    ir_ready   = 1'b0;
    npc_valid  = 1'b0;
    npc        = 32'd0;
    #2 rst = 1'b0;
    // Pending ack during reset must be ignored
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    m_pc = 32'h0000_3000; m_ir = 32'd0; m_cnt = 32'd0;
    chk("rst.ir", ir, 32'd0);
    chk("rst.pc", pc, 32'h0000_3000);
    chk("rst.cnt", instr_cnt, 32'd0);
    chk("rst.ir_valid", {31'd0, ir_valid}, 32'd0);
    chk("rst.misalign", {31'd0, misalign}, 32'd0);
    step(); step();
    chk("rst_ack.ir", ir, 32'd0);
    chk("rst_ack.ir_valid", {31'd0, ir_valid}, 32'd0);

    // Reset release, ack in first fetch cycle
    imem_ack = 1'b0;
    rst = 1'b1;
    #1;
    chk_fetch("rel");
    imem_ack   = 1'b1;
    imem_rdata = 32'h2008_0005;
    step();
    imem_ack = 1'b0;
    m_ir = 32'h2008_0005;
    chk_hold("first");

    // Sequential run: 3 instructions, 2 cycles each
    for (int i = 0; i < 3; i++) begin
      ir_ready  = 1'b1;
      npc_valid = 1'b1;
      npc       = m_pc + 32'd4;
      step();
      ir_ready  = 1'b0;
      npc_valid = 1'b0;
      m_cnt = m_cnt + 32'd1;
      m_pc  = m_pc + 32'd4;
      chk_fetch("seq.f");
      imem_ack   = 1'b1;
      imem_rdata = $urandom;
      step();
      imem_ack = 1'b0;
      m_ir = imem_rdata;
      chk_hold("seq.h");
    end
    chk("seq.cnt3", instr_cnt, 32'd3);
    chk("seq.pc", pc, 32'h0000_300C);

    // Decode stall: npc and acks must be ignored while not accepted
    for (int i = 0; i < 5; i++) begin
      npc_valid  = 1'b1;
      npc        = 32'h0000_5000;
      imem_ack   = 1'b1;
      imem_rdata = 32'hBAD0_0000;
      step();
      chk_hold("stall");
    end
    npc_valid = 1'b0;
    imem_ack  = 1'b0;

    // Late npc: three cycles in WAIT_NPC
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0;
    m_cnt = m_cnt + 32'd1;
    chk_wait("late1");
    for (int i = 0; i < 2; i++) begin
      imem_ack   = 1'b1;
      imem_rdata = $urandom;
      step();
      chk_wait("late");
    end
    imem_ack  = 1'b0;
    npc_valid = 1'b1;
    npc       = 32'h0000_3040;
    step();
    npc_valid = 1'b0;
    m_pc = 32'h0000_3040;
    chk_fetch("late.f");

    // Randomized run against the transaction model
    for (int n = 0; n < 25; n++) begin
      int lat;
      int stl;
      int dly;
      lat = $urandom_range(0, 3);
      stl = $urandom_range(0, 3);
      dly = $urandom_range(0, 3);
      for (int k = 0; k < lat; k++) begin
        imem_ack  = 1'b0;
        npc_valid = 1'($urandom_range(0, 1));
        npc       = $urandom;
        step();
        chk_fetch("rnd.fw");
      end
      npc_valid  = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = $urandom;
      step();
      m_ir = imem_rdata;
      chk_hold("rnd.h");
      for (int k = 0; k < stl; k++) begin
        imem_ack   = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
        npc_valid  = 1'($urandom_range(0, 1));
        npc        = $urandom;
        step();
        chk_hold("rnd.stall");
      end
      imem_ack  = 1'b0;
      nxt       = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      ir_ready  = 1'b1;
      npc_valid = (dly == 0);
      npc       = nxt;
      step();
      ir_ready  = 1'b0;
      npc_valid = 1'b0;
      m_cnt = m_cnt + 32'd1;
      if (dly != 0) begin
        chk_wait("rnd.w");
        for (int k = 1; k < dly; k++) begin
          imem_ack   = 1'($urandom_range(0, 1));
          imem_rdata = $urandom;
          step();
          chk_wait("rnd.w");
        end
        imem_ack  = 1'b0;
        npc_valid = 1'b1;
        npc       = nxt;
        step();
        npc_valid = 1'b0;
      end
      m_pc = nxt;
      chk_fetch("rnd.f");
    end

    // Misaligned next-PC target
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    step();
    imem_ack = 1'b0;
    m_ir = 32'h1234_5678;
    chk_hold("mis.h");
    ir_ready  = 1'b1;
    npc_valid = 1'b1;
    npc       = 32'h0000_3042;
    step();
    m_cnt = m_cnt + 32'd1;
`ifdef FETCH_ALIGN_CHECK_EN
    for (int k = 0; k < 4; k++) begin
      chk("mis.flag", {31'd0, misalign}, 32'd1);
      chk("mis.pc", pc, m_pc);
      chk_wait("mis.err");
      imem_ack   = 1'b1;
      imem_rdata = $urandom;
      ir_ready   = 1'b1;
      npc_valid  = 1'b1;
      npc        = 32'h0000_4000;
      step();
    end
`else
    m_pc = 32'h0000_3040;
    chk("mis.flag", {31'd0, misalign}, 32'd0);
    chk_fetch("mis.f");
`endif
    ir_ready  = 1'b0;
    npc_valid = 1'b0;

    // Reset in the middle of a fetch with ack asserted
    imem_ack   = 1'b1;
    imem_rdata = 32'hFEED_FACE;
    #2 rst = 1'b0;
    #1;
    m_pc = 32'h0000_3000; m_ir = 32'd0; m_cnt = 32'd0;
    chk("rst2.ir", ir, 32'd0);
    chk("rst2.pc", pc, 32'h0000_3000);
    chk("rst2.cnt", instr_cnt, 32'd0);
    chk("rst2.misalign", {31'd0, misalign}, 32'd0);
    step(); step();
    chk("rst2.ir_hold", ir, 32'd0);
    imem_ack = 1'b0;
    rst = 1'b1;
    #1;
    chk_fetch("rst2.rel");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, giving the PC loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port imem_req, output, 1, instruction-memory read request.
REQ-005 SHALL have port imem_addr, output, 32, read address, always equal to pc.
REQ-006 SHALL have port imem_ack, input, 1, memory read done; imem_rdata valid in the same cycle.
REQ-007 SHALL have port imem_rdata, input, 32, fetched instruction word.
REQ-008 SHALL have port pc, output, 32, address of the instruction in ir.
REQ-009 SHALL have port ir, output, 32, instruction register.
REQ-010 SHALL have port ir_valid, output, 1, ir/pc offered to decode.
REQ-011 SHALL have port ir_ready, input, 1, decode accepts ir.
REQ-012 SHALL have port npc_valid, input, 1, next-PC result available.
REQ-013 SHALL have port npc, input, 32, next PC from the next-PC unit.
REQ-014 SHALL have port instr_cnt, output, 32, count of instructions accepted by decode.
REQ-015 SHALL have port misalign, output, 1, sticky misaligned-target flag (tied 0 when feature absent).

Function
REQ-016 SHALL implement FSM states FETCH, HOLD, WAIT_NPC, ERROR.
REQ-017 FETCH: imem_req=1, imem_addr=pc held stable; on imem_ack, ir<=imem_rdata and go to HOLD next cycle.
REQ-018 imem_ack outside FETCH SHALL be ignored; ir SHALL change only on a FETCH ack.
REQ-019 HOLD: ir_valid=1, ir and pc stable; on ir_valid&&ir_ready, instr_cnt increments by 1 (wraps 32'hFFFF_FFFF->0) and go to WAIT_NPC.
REQ-020 HOLD with ir_ready&&npc_valid in the same cycle: accept npc immediately, increment instr_cnt, go directly to FETCH (skip WAIT_NPC).
REQ-021 WAIT_NPC: ir_valid=0, imem_req=0; on npc_valid, pc<=npc and go to FETCH.
REQ-022 npc_valid in FETCH, or in HOLD without ir_ready, SHALL be ignored.
REQ-023 Minimum instruction period SHALL be 2 cycles (ack in first FETCH cycle, handshake and npc together in HOLD).
REQ-024 imem_req and ir_valid SHALL be registered outputs decoded from state only, never both 1.

Reset
REQ-025 rst low SHALL immediately force: state FETCH, pc=RESET_PC, ir=0, instr_cnt=0, misalign=0.
REQ-026 ir_valid SHALL be 0 while rst is low; imem_req SHALL go to 1 once rst deasserts.
REQ-027 Reset mid-fetch or mid-handshake SHALL abandon the transaction; a pending ack SHALL be ignored while rst is low.

Configuration
REQ-028 With FETCH_ALIGN_CHECK_EN defined, an accepted npc with npc[1:0]!=0 SHALL leave pc unchanged, set misalign=1, and enter ERROR.
REQ-029 ERROR SHALL drive imem_req=0 and ir_valid=0, ignore all inputs, and exit only via reset.
REQ-030 Without FETCH_ALIGN_CHECK_EN, pc SHALL load {npc[31:2],2'b00}, misalign SHALL be constant 0, and ERROR SHALL be unreachable.

Verification
REQ-031 Reset release, imem_ack at cycle 1 with data 32'h2008_0005 -> imem_addr=32'h0000_3000, ir=32'h2008_0005, ir_valid=1 next cycle.
REQ-032 Sequential run: ir_ready=1 held, npc=pc+4 supplied on handshake, 3 instructions -> pc 3000/3004/3008, instr_cnt=3, 2 cycles per instruction.
REQ-033 Decode stall: ir_ready=0 for 5 cycles in HOLD -> ir and pc unchanged, no imem_req, instr_cnt unchanged.
REQ-034 Late npc: handshake, then npc_valid after 3 cycles with npc=32'h0000_3040 -> WAIT_NPC for 3 cycles, then imem_addr=32'h0000_3040.
REQ-035 With FETCH_ALIGN_CHECK_EN, npc=32'h0000_3042 -> misalign=1, imem_req=0 persistently; without it, imem_addr=32'h0000_3040.
REQ-036 rst low during FETCH with imem_ack=1 -> ir stays 0, pc=RESET_PC, instr_cnt=0.
